// File: rtl/edge_zbt_pixel_packer.sv
// Packs pairs of 18-bit reduced pixels (even/odd column) into 36-bit ZBT words
// and queues them in a small FIFO for the ZBT write arbiter (valid/ready).
module edge_zbt_pixel_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [23:0]       pix_rgb,
    input  logic [10:0]       pix_hcount,
    input  logic [9:0]        pix_vcount,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [35:0]       wr_data,
    output logic              overflow,
    output logic              misaligned
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = ADDR_W + 36;

    typedef enum logic {
        WAIT_LO,
        WAIT_HI
    } state_t;

    state_t              state_q, state_d, cur_state;
    logic [17:0]         lo_q, lo_d;
    logic [ADDR_W-1:0]   la_q, la_d;
    logic                mis_q, mis_set;
    logic                ovf_q;

    logic [17:0]         p18;
    logic [ADDR_W-1:0]   waddr;
    logic                unused_vcount_msb;

    logic                push, push_ok, pop, full;
    logic [ADDR_W-1:0]   push_addr;
    logic [35:0]         push_data;

    logic [EW-1:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         count_q, count_d, remaining;
    logic [EW-1:0]       head_q, head_d;

    assign p18               = {pix_rgb[23:18], pix_rgb[15:10], pix_rgb[7:2]};
    assign waddr             = {pix_vcount[8:0], pix_hcount[10:1]};
    assign unused_vcount_msb = pix_vcount[9];

    // frame_start is applied before the pixel of the same cycle is processed
    assign cur_state = frame_start ? WAIT_LO : state_q;

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        la_d      = la_q;
        mis_set   = 1'b0;
        push      = 1'b0;
        push_addr = '0;
        push_data = '0;
        if (frame_start) begin
            state_d = WAIT_LO;
            lo_d    = '0;
        end
        if (pix_valid) begin
            case (cur_state)
                WAIT_LO: begin
                    if (!pix_hcount[0]) begin
                        lo_d    = p18;
                        la_d    = waddr;
                        state_d = WAIT_HI;
                    end else begin
                        push      = 1'b1;
                        push_addr = waddr;
                        push_data = {p18, 18'b0};
                        state_d   = WAIT_LO;
                    end
                end
                WAIT_HI: begin
                    push      = 1'b1;
                    push_addr = la_q;
                    if (!pix_hcount[0]) begin
                        push_data = {18'b0, lo_q};
                        lo_d      = p18;
                        la_d      = waddr;
                        state_d   = WAIT_HI;
                    end else if (waddr == la_q) begin
                        push_data = {p18, lo_q};
                        state_d   = WAIT_LO;
                    end else begin
                        push_data = {18'b0, lo_q};
                        mis_set   = 1'b1;
                        state_d   = WAIT_LO;
                    end
                end
                default: state_d = WAIT_LO;
            endcase
        end
    end

    assign wr_valid = (count_q != '0);
    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign pop      = wr_valid & wr_ready;
    assign push_ok  = push & (~full | pop);

    assign count_d   = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
    assign remaining = count_q - {{PW{1'b0}}, pop};

    // The head register tracks the entry at the post-update read pointer, falling
    // back to the incoming word when the FIFO would otherwise be empty.
    always_comb begin
        head_d = head_q;
        if (remaining != '0)
            head_d = mem[rd_ptr_q + PW'(pop)];
        else if (push_ok)
            head_d = {push_addr, push_data};
    end

    always_ff @(posedge clock) begin
        if (push_ok)
            mem[wr_ptr_q] <= {push_addr, push_data};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= WAIT_LO;
            lo_q     <= '0;
            la_q     <= '0;
            mis_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            la_q     <= la_d;
            if (mis_set)
                mis_q <= 1'b1;
            if (push && !push_ok)
                ovf_q <= 1'b1;
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign wr_addr    = head_q[EW-1:36];
    assign wr_data    = head_q[35:0];
    assign overflow   = ovf_q;
    assign misaligned = mis_q;

endmodule
